// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks a combinational function block through every
// input code, captures its output into a table, then streams the indices of
// the set bits (the minterms) over a valid/ready handshake.
module truth_table_scanner #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    output logic [N_IN-1:0]          o_x,
    input  logic                     i_z,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [(1<<N_IN)-1:0]     o_table,
    output logic [N_IN:0]            o_count,
    output logic                     o_m_valid,
    input  logic                     i_m_ready,
    output logic [N_IN-1:0]          o_m_index,
    output logic                     o_m_last
);

    localparam int TW = 1 << N_IN;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(TW - 1);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REPORT,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [N_IN-1:0]     r_x;
    logic [N_IN-1:0]     r_idx;
    logic [SW-1:0]       r_settle;
    logic [TW-1:0]       r_table;
    logic [N_IN:0]       r_count;
    logic [N_IN-1:0]     r_ptr;

    logic                w_captureNow;
    logic                w_scanEnd;
    logic                w_bitSet;
    logic                w_above;
    logic                w_mValid;
    logic                w_mLast;
    logic                w_reportStep;
    logic                w_reportDone;

    // The last cycle of the settle window at the current code is the one
    // where z is trusted and written into the table.
    assign w_captureNow = (r_state == S_SCAN) && (r_settle == SETTLE_LAST);
    assign w_scanEnd    = w_captureNow && (r_idx == LAST_IDX);

    // A zero entry is skipped in one cycle; a set entry waits for the
    // consumer. The walk ends at the top index or on the accepted last beat.
    assign w_bitSet     = r_table[r_ptr];
    assign w_mValid     = (r_state == S_REPORT) && w_bitSet;
    assign w_mLast      = w_mValid && !w_above;
    assign w_reportStep = (r_state == S_REPORT) && (!w_bitSet || i_m_ready);
    assign w_reportDone = w_reportStep && ((r_ptr == LAST_IDX) || w_mLast);

    // Look for any set table bit strictly above the report pointer so the
    // final minterm can be flagged without a second pass.
    always_comb begin
        w_above = 1'b0;
        for (int i = 0; i < TW; i++) begin
            if ((i > int'(r_ptr)) && r_table[i]) begin
                w_above = 1'b1;
            end
        end
    end

    // State register; reset wins over everything including a pending start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection plus the status outputs decoded from the state.
    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                o_busy = 1'b1;
                if (w_scanEnd) begin
                    w_next = S_REPORT;
                end
            end
            S_REPORT: begin
                o_busy = 1'b1;
                if (w_reportDone) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: stimulus code, settle timer, captured table, popcount and
    // the report pointer. The table survives in IDLE until the next start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x      <= '0;
            r_idx    <= '0;
            r_settle <= '0;
            r_table  <= '0;
            r_count  <= '0;
            r_ptr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x      <= '0;
                        r_idx    <= '0;
                        r_settle <= '0;
                        r_table  <= '0;
                        r_count  <= '0;
                        r_ptr    <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_captureNow) begin
                        r_table[r_idx] <= i_z;
                        r_count        <= r_count + {{N_IN{1'b0}}, i_z};
                        if (r_idx == LAST_IDX) begin
                            r_ptr <= '0;
                        end else begin
                            r_idx    <= r_idx + N_IN'(1);
                            r_x      <= r_idx + N_IN'(1);
                            r_settle <= '0;
                        end
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                S_REPORT: begin
                    if (w_reportStep && !w_reportDone) begin
                        r_ptr <= r_ptr + N_IN'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_x       = r_x;
    assign o_table   = r_table;
    assign o_count   = r_count;
    assign o_m_valid = w_mValid;
    assign o_m_index = r_ptr;
    assign o_m_last  = w_mLast;

endmodule
